regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the fixed 32x32 combinational read mux of the datapath.
- Owns the storage array, one write port and NUM_RD independently addressed, registered read ports.
- Sits in the decode stage and feeds operand registers to the ALU path.
- Adds per-port read enables with output hold, an optional hardwired zero register and an optional write-to-read bypass.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are dropped.

Ports:
- Clk  in  1  single clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- WrEn  in  1  write strobe.
- Awr  in  ADDR_W  write address.
- Din  in  DATA_W  write data.
- RdEn  in  NUM_RD  per-port read enable; bit k belongs to port k.
- Ard  in  NUM_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- Dout  out  NUM_RD*DATA_W  registered read data; port k is bits [k*DATA_W +: DATA_W].
- DoutVld  out  NUM_RD  per-port flag: Dout of that port was updated by a read in the previous cycle.

Behaviour:
- Reset is synchronous and active-high on Clk. While Rst=1 at a rising edge:
  - all registers clear to 0;
  - Dout clears to 0;
  - DoutVld clears to 0;
  - WrEn and RdEn are ignored that cycle.
- Write: at a rising edge with Rst=0 and WrEn=1, reg[Awr] <= Din. If ZERO_REG=1 and Awr=0, no write takes place.
- Read, 1-cycle latency: at a rising edge with RdEn[k]=1:
  - Dout port k <= reg[Ard port k], using the array value before this edge's write (no bypass build);
  - DoutVld[k] <= 1.
- Hold: with RdEn[k]=0:
  - Dout port k keeps its previous value;
  - DoutVld[k] <= 0.
- Zero register: if ZERO_REG=1 and Ard port k=0, the read returns 0 regardless of array content.
- Multiple ports reading the same address in the same cycle all receive the same value. No arbitration; no stall.
- Write and read to the same address in the same cycle, no bypass build: the read returns the old value and the new value is visible from the next read onward.
- Addresses wrap naturally; every ADDR_W value is legal and no out-of-range case exists.
- Reset asserted mid-stream: it overrides any simultaneous write or read. No partial write survives.
- No X on outputs after the first reset. Before the first reset, outputs are undefined.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: when WrEn=1, RdEn[k]=1 and Ard port k equals Awr in the same cycle, Dout port k <= Din (write-through).
  - The ZERO_REG rule still wins: address 0 with ZERO_REG=1 returns 0.
  - Rst still wins over the bypass.
- Undefined: no bypass; the same-address read returns the old value.

Decomposition:
- Package regfile_pkg:
  - constants DEF_DATA_W=32, DEF_ADDR_W=5, MAX_RD=4;
  - typedef word_t (logic [DEF_DATA_W-1:0]);
  - typedef addr_t (logic [DEF_ADDR_W-1:0]).
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate. Each instance contains:
  - the address-decode mux;
  - the zero-register gate;
  - the bypass compare when compiled in;
  - the Dout/DoutVld output register with hold.
- The storage array and write logic stay in the top level.

Test Plan:
- Reset then read: Rst=1 for one edge, then RdEn=11 with Ard0=5, Ard1=31 -> next cycle Dout0=0, Dout1=0, DoutVld=11.
- Write/read back: WrEn=1, Awr=7, Din=0xDEADBEEF; next cycle RdEn[0]=1, Ard0=7 -> one cycle later Dout0=0xDEADBEEF, DoutVld[0]=1.
- Zero register: WrEn=1, Awr=0, Din=0x12345678, then read Ard0=0 -> Dout0=0x00000000.
- Same-address collision: WrEn=1, Awr=3, Din=0xA5A5A5A5, with reg3 previously 0x11111111, and RdEn[1]=1, Ard1=3 in the same cycle -> Dout1 result depends on the build:
  - without the macro, Dout1=0x11111111;
  - with REGFILE_WR_BYPASS_EN, Dout1=0xA5A5A5A5;
  - either way, a read of reg3 on the following cycle returns 0xA5A5A5A5.
- Hold: Dout0=0xDEADBEEF, then RdEn[0]=0 for 3 cycles while Ard0 changes -> Dout0 stays 0xDEADBEEF, DoutVld[0]=0.
- Reset mid-operation: WrEn=1, Awr=9, Din=0xFFFFFFFF together with Rst=1 -> a later read of reg9 returns 0, and Dout/DoutVld are 0 after the reset edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Optional build macro: REGFILE_WR_BYPASS_EN (write-to-read bypass in the read ports).
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int MAX_RD     = 4;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of the register file.
// Picks one register by address, forces register 0 to read as zero when the
// zero register is enabled, optionally forwards same-cycle write data
// (macro REGFILE_WR_BYPASS_EN), and holds its output when not enabled.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] regs [DEPTH],
`ifdef REGFILE_WR_BYPASS_EN
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
`endif
    output logic [DATA_W-1:0] rdData,
    output logic              rdVld
);

    logic [DATA_W-1:0] selData;

    // Select the addressed word; forwarding and the zero gate are applied last so zero always wins
    always_comb begin
        selData = regs[rdAddr];
`ifdef REGFILE_WR_BYPASS_EN
        if (wrEn && (wrAddr == rdAddr)) begin
            selData = wrData;
        end
`endif
        if ((ZERO_REG == 1) && (rdAddr == '0)) begin
            selData = '0;
        end
    end

    // Capture on enable, otherwise hold data and drop the valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= '0;
            rdVld  <= 1'b0;
        end else if (rdEn) begin
            rdData <= selData;
            rdVld  <= 1'b1;
        end else begin
            rdVld  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: storage array with one write port
// and NUM_RD independently addressed, registered read ports.
// Optional build macro: REGFILE_WR_BYPASS_EN (same-cycle write-through to reads).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        Awr,
    input  logic [DATA_W-1:0]        Din,
    input  logic [NUM_RD-1:0]        RdEn,
    input  logic [NUM_RD*ADDR_W-1:0] Ard,
    output logic [NUM_RD*DATA_W-1:0] Dout,
    output logic [NUM_RD-1:0]        DoutVld
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              writeFire;

    // A write to register 0 is dropped when it is hardwired to zero
    always_comb begin
        writeFire = WrEn;
        if ((ZERO_REG == 1) && (Awr == '0)) begin
            writeFire = 1'b0;
        end
    end

    // Storage array: reset clears every register, otherwise one write per cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (writeFire) begin
            mem[Awr] <= Din;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRdPort
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) uRdPort (
            .clk    (Clk),
            .rst    (Rst),
            .rdEn   (RdEn[k]),
            .rdAddr (Ard[k*ADDR_W +: ADDR_W]),
            .regs   (mem),
`ifdef REGFILE_WR_BYPASS_EN
            .wrEn   (writeFire),
            .wrAddr (Awr),
            .wrData (Din),
`endif
            .rdData (Dout[k*DATA_W +: DATA_W]),
            .rdVld  (DoutVld[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (32 x 32, two read ports, zero register enabled).
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        WrEn;
    addr_t       Awr;
    word_t       Din;
    logic [1:0]  RdEn;
    logic [9:0]  Ard;
    logic [63:0] Dout;
    logic [1:0]  DoutVld;

    int checks = 0;
    int errors = 0;

    word_t dout0;
    word_t dout1;
    word_t collideExp;

    assign dout0 = Dout[31:0];
    assign dout1 = Dout[63:32];

    regfile_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .WrEn    (WrEn),
        .Awr     (Awr),
        .Din     (Din),
        .RdEn    (RdEn),
        .Ard     (Ard),
        .Dout    (Dout),
        .DoutVld (DoutVld)
    );

    // Free-running clock, 10 time units per period
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive one cycle's inputs, then let one rising edge pass and settle
    task automatic applyStimulus(input logic rst, input logic wrEn, input addr_t awr,
                                 input word_t din, input logic [1:0] rdEn,
                                 input addr_t ard0, input addr_t ard1);
        Rst  = rst;
        WrEn = wrEn;
        Awr  = awr;
        Din  = din;
        RdEn = rdEn;
        Ard  = {ard1, ard0};
        @(posedge Clk);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        Rst = 1'b0; WrEn = 1'b0; Awr = '0; Din = '0; RdEn = '0; Ard = '0;
        @(negedge Clk);

        // Reset
        applyStimulus(1, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("rst_dout0", dout0, 32'h0);
        checkOutput("rst_dout1", dout1, 32'h0);
        checkOutput("rst_vld", {30'd0, DoutVld}, 32'h0);

        // Read after reset
        applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd31);
        checkOutput("rd_after_rst_dout0", dout0, 32'h0);
        checkOutput("rd_after_rst_dout1", dout1, 32'h0);
        checkOutput("rd_after_rst_vld", {30'd0, DoutVld}, 32'h3);

        // Write reg7, then read it back on port 0
        applyStimulus(0, 1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
        checkOutput("wr7_vld_low", {30'd0, DoutVld}, 32'h0);
        applyStimulus(0, 0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0);
        checkOutput("rd7_dout0", dout0, 32'hDEADBEEF);
        checkOutput("rd7_vld", {30'd0, DoutVld}, 32'h1);

        // Hold for three cycles while the port-0 address moves
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 5'd0, 32'h0, 2'b00, 5'(i), 5'(i + 10));
            checkOutput($sformatf("hold%0d_dout0", i), dout0, 32'hDEADBEEF);
            checkOutput($sformatf("hold%0d_vld", i), {30'd0, DoutVld}, 32'h0);
        end

        // Zero register: write to 0 with a same-cycle read of 0, then read again
        applyStimulus(0, 1, 5'd0, 32'h12345678, 2'b01, 5'd0, 5'd0);
        checkOutput("zero_same_cycle", dout0, 32'h0);
        applyStimulus(0, 0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0);
        checkOutput("zero_next_read", dout0, 32'h0);

        // Same-address collision on port 1
        applyStimulus(0, 1, 5'd3, 32'h11111111, 2'b00, 5'd0, 5'd0);
`ifdef REGFILE_WR_BYPASS_EN
        collideExp = 32'hA5A5A5A5;
`else
        collideExp = 32'h11111111;
`endif
        applyStimulus(0, 1, 5'd3, 32'hA5A5A5A5, 2'b10, 5'd0, 5'd3);
        checkOutput("collide_dout1", dout1, collideExp);
        checkOutput("collide_dout0_hold", dout0, 32'h0);
        checkOutput("collide_vld", {30'd0, DoutVld}, 32'h2);
        applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3);
        checkOutput("after_collide_dout0", dout0, 32'hA5A5A5A5);
        checkOutput("after_collide_dout1", dout1, 32'hA5A5A5A5);

        // Two ports at distinct addresses, including the top address
        applyStimulus(0, 1, 5'd31, 32'h0BADF00D, 2'b00, 5'd0, 5'd0);
        applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd31, 5'd7);
        checkOutput("dual_dout0_r31", dout0, 32'h0BADF00D);
        checkOutput("dual_dout1_r7", dout1, 32'hDEADBEEF);

        // Reset overrides a simultaneous write and read
        applyStimulus(1, 1, 5'd9, 32'hFFFFFFFF, 2'b11, 5'd7, 5'd31);
        checkOutput("midrst_dout0", dout0, 32'h0);
        checkOutput("midrst_dout1", dout1, 32'h0);
        checkOutput("midrst_vld", {30'd0, DoutVld}, 32'h0);
        applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7);
        checkOutput("post_rst_r9", dout0, 32'h0);
        checkOutput("post_rst_r7", dout1, 32'h0);
        checkOutput("post_rst_vld", {30'd0, DoutVld}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
